intersection_scheduler: RTL and testbench
=========================================

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 8: minimum green dwell in cycles (>=1).
REQ-002 SHALL have parameter GREEN_MAX, default 32: maximum green dwell under contention (>=GREEN_MIN).
REQ-003 SHALL have parameter YELLOW_T, default 3: yellow dwell in cycles (>=1).
REQ-004 SHALL have parameter CLEAR_T, default 2: all-red clearance in cycles (>=1).
REQ-005 SHALL have parameter PED_T, default 6: pedestrian walk dwell in cycles (>=1).
REQ-006 SHALL have parameter TW, default 6: phase counter width; every duration SHALL fit in TW bits.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 req_a  input  1  vehicle demand on road A (level).
REQ-010 req_b  input  1  vehicle demand on road B (level).
REQ-011 req_ped  input  1  pedestrian button (any-length pulse, latched).
REQ-012 l_a  output  2  road A lamp: 0 green, 1 yellow, 2 red.
REQ-013 l_b  output  2  road B lamp, same encoding.
REQ-014 walk  output  1  pedestrian walk lamp.
REQ-015 ped_ack  output  1  one-cycle pulse on PED_WALK entry.
REQ-016 phase  output  3  current state code.

Function
REQ-017 States/codes: A_GREEN 0, A_YELLOW 1, A_CLEAR 2, B_GREEN 3, B_YELLOW 4, B_CLEAR 5, PED_WALK 6; code 7 unreachable, SHALL recover to A_GREEN next cycle.
REQ-018 Outputs Moore-decoded from state: l_a=0/1 in A_GREEN/A_YELLOW else 2; l_b=0/1 in B_GREEN/B_YELLOW else 2; walk=1 only in PED_WALK.
REQ-019 Phase counter cnt clears to 0 on every state entry, increments each cycle in state, saturates at GREEN_MAX-1.
REQ-020 Timed states (YELLOW, CLEAR, PED_WALK) SHALL dwell exactly their duration: exit when cnt==DUR-1.
REQ-021 Competing demand for green X: req of other road OR ped_pending.
REQ-022 Green gap-out: leave to own YELLOW when cnt>=GREEN_MIN-1, competing demand=1, own req=0.
REQ-023 Green max-out: leave to own YELLOW when cnt==GREEN_MAX-1 and competing demand=1, regardless of own req.
REQ-024 No competing demand: green held indefinitely, cnt saturated.
REQ-025 X_YELLOW -> X_CLEAR; X_CLEAR -> PED_WALK if ped_pending, else other road's GREEN.
REQ-026 last_dir register SHALL record road of the most recent CLEAR; PED_WALK exits to GREEN of the road opposite last_dir.
REQ-027 ped_pending SHALL set on any cycle req_ped=1 and clear on PED_WALK entry; req_ped=1 in the entry cycle is absorbed by that walk.
REQ-028 req_ped during PED_WALK (after entry cycle) SHALL set ped_pending for the next cycle of service.
REQ-029 ped_ack SHALL be 1 exactly in the first PED_WALK cycle.

Reset
REQ-030 reset=1 SHALL force, at next edge: state A_GREEN, cnt 0, ped_pending 0, last_dir B; outputs l_a=0, l_b=2, walk=0, ped_ack=0, phase=0.
REQ-031 reset mid-phase (any state) SHALL abandon the phase with no intermediate yellow/clear; pending pedestrian demand is lost.

Structure
REQ-032 Shared package intersection_pkg SHALL hold the state enum/codes and lamp constants GREEN=0, YELLOW=1, RED=2.
REQ-033 Single sub-module phase_timer (clear, saturating up-count, TW wide) SHALL implement cnt.

Verification
REQ-034 Reset, all requests 0 for 100 cycles -> l_a=0, l_b=2, phase=0 throughout.
REQ-035 After reset, req_b=1, req_a=0 held -> A green 8 cycles, yellow 3, all-red 2, l_b=0 from cycle 13.
REQ-036 req_a=1, req_b=1 held -> A green exactly 32 cycles, then yellow 3, clear 2, B green 32 cycles.
REQ-037 One-cycle req_ped during A_GREEN, req_b=0 -> after cycle 8 A yellow/clear, walk=1 for 6 cycles, ped_ack single pulse, then B_GREEN.
REQ-038 req_ped pulse in PED_WALK cycle 3 -> walk ends normally, re-served after next green gap-out/max-out.
REQ-039 reset=1 for one cycle in B_YELLOW with ped_pending=1 -> next cycle phase=0, walk=0, no PED_WALK afterward without new req_ped.

Source files
------------

// File: rtl/intersection_pkg.sv
// intersection_pkg: shared definitions for the intersection scheduler.
//   phase_e : controller state; the encoding is also the external phase code.
//   dir_e   : road identifier used to remember which road cleared last.
//   GREEN/YELLOW/RED : lamp encoding driven on l_a / l_b.
package intersection_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    A_CLEAR  = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    B_CLEAR  = 3'd5,
    PED_WALK = 3'd6
  } phase_e;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } dir_e;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] RED    = 2'd2;

endpackage

// File: rtl/intersection_scheduler_if.sv
// intersection_scheduler_if: bundles the demand inputs and lamp outputs.
//   req_a, req_b : vehicle demand per road (levels)
//   req_ped      : pedestrian button (any-length pulse)
//   l_a, l_b     : lamp codes (GREEN/YELLOW/RED)
//   walk         : pedestrian walk lamp
//   ped_ack      : one-cycle pulse on the first walk cycle
//   phase        : current controller state code (debug/observability)
// Signalling: there is no valid/ready pairing here. Every request is sampled
// on each rising clk edge and every output is a registered, Moore-decoded
// level that is valid in every cycle after reset.
// modport master drives the requests (environment); modport slave is the
// scheduler.
interface intersection_scheduler_if;
  logic       req_a;
  logic       req_b;
  logic       req_ped;
  logic [1:0] l_a;
  logic [1:0] l_b;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output req_a, req_b, req_ped,
    input  l_a, l_b, walk, ped_ack, phase
  );

  modport slave (
    input  req_a, req_b, req_ped,
    output l_a, l_b, walk, ped_ack, phase
  );
endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// phase_timer: TW-bit phase counter. Clears to 0 when clear=1, otherwise
// counts up once per cycle and holds at SAT.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   clear      : restart count from 0 on the next edge
//   cnt        : current count
module phase_timer #(
  parameter int TW  = 6,
  parameter int SAT = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic [TW-1:0] cnt
);
  localparam logic [TW-1:0] SAT_V = TW'(SAT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != SAT_V) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-road traffic light controller with a latched
// pedestrian walk phase.
//   clk, reset : clock, synchronous active-high reset
//   bus        : intersection_scheduler_if.slave (requests in, lamps out,
//                phase exposes the FSM state)
// Green dwells at least GREEN_MIN cycles, gaps out early when the own road
// goes idle and someone else waits, and maxes out at GREEN_MAX under
// contention. Yellow, all-red clearance and walk have fixed dwells.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 3,
  parameter int CLEAR_T   = 2,
  parameter int PED_T     = 6,
  parameter int TW        = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  intersection_scheduler_if.slave  bus
);
  localparam logic [TW-1:0] GMIN_M1 = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_M1 = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] CLR_M1  = TW'(CLEAR_T - 1);
  localparam logic [TW-1:0] PED_M1  = TW'(PED_T - 1);

  phase_e        state_q, state_d;
  dir_e          last_dir_q, last_dir_d;
  logic          ped_pending_q, ped_pending_d;
  logic          ped_ack_q, ped_ack_d;
  logic [TW-1:0] cnt;
  logic          enter_walk;
  logic          comp_a, comp_b;

  // The counter restarts on every state change, so cnt is always the number
  // of cycles already spent in the current state (saturating).
  phase_timer #(.TW(TW), .SAT(GREEN_MAX - 1)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_d != state_q),
    .cnt   (cnt)
  );

  assign comp_a = bus.req_b | ped_pending_q;
  assign comp_b = bus.req_a | ped_pending_q;

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      A_GREEN: begin
        if ((cnt >= GMIN_M1 && comp_a && !bus.req_a) || (cnt == GMAX_M1 && comp_a))
          state_d = A_YELLOW;
      end
      A_YELLOW: if (cnt == YEL_M1) state_d = A_CLEAR;
      A_CLEAR: begin
        last_dir_d = DIR_A;
        if (cnt == CLR_M1) state_d = ped_pending_q ? PED_WALK : B_GREEN;
      end
      B_GREEN: begin
        if ((cnt >= GMIN_M1 && comp_b && !bus.req_b) || (cnt == GMAX_M1 && comp_b))
          state_d = B_YELLOW;
      end
      B_YELLOW: if (cnt == YEL_M1) state_d = B_CLEAR;
      B_CLEAR: begin
        last_dir_d = DIR_B;
        if (cnt == CLR_M1) state_d = ped_pending_q ? PED_WALK : A_GREEN;
      end
      PED_WALK: begin
        // Hand green to the road that did not clear most recently.
        if (cnt == PED_M1) state_d = (last_dir_q == DIR_A) ? B_GREEN : A_GREEN;
      end
      default: state_d = A_GREEN;  // code 7 recovers in one cycle
    endcase
  end

  // Presses on the transition edge and during the first walk cycle belong to
  // the walk being started; later presses queue another walk.
  always_comb begin
    enter_walk    = (state_d == PED_WALK) && (state_q != PED_WALK);
    ped_ack_d     = enter_walk;
    ped_pending_d = ped_pending_q | (bus.req_ped & ~ped_ack_q);
    if (enter_walk) ped_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= A_GREEN;
      last_dir_q    <= DIR_B;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_dir_q    <= last_dir_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  assign bus.l_a     = (state_q == A_GREEN)  ? GREEN :
                       (state_q == A_YELLOW) ? YELLOW : RED;
  assign bus.l_b     = (state_q == B_GREEN)  ? GREEN :
                       (state_q == B_YELLOW) ? YELLOW : RED;
  assign bus.walk    = (state_q == PED_WALK);
  assign bus.ped_ack = ped_ack_q;
  assign bus.phase   = state_q;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed sequences with hand-counted phase
// timelines for the default parameters. Each driven cycle pushes the
// expected {phase, l_a, l_b, walk, ped_ack} onto exp_q; the monitor pops
// and compares on every falling edge.
module tb_intersection_scheduler;

  logic clk;
  logic reset;

  intersection_scheduler_if bus ();

  intersection_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  string      name_q[$];
  int         n_vec;
  int         n_err;

  // Lamp expectations written directly from the lamp table.
  function automatic logic [8:0] make_exp(input logic [2:0] ph, input logic ack);
    logic [1:0] la, lb;
    la = (ph == 3'd0) ? 2'd0 : (ph == 3'd1) ? 2'd1 : 2'd2;
    lb = (ph == 3'd3) ? 2'd0 : (ph == 3'd4) ? 2'd1 : 2'd2;
    return {ph, la, lb, (ph == 3'd6), ack};
  endfunction

  logic [8:0] got_v, exp_v;
  string      cur_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v    = exp_q.pop_front();
      cur_name = name_q.pop_front();
      got_v    = {bus.phase, bus.l_a, bus.l_b, bus.walk, bus.ped_ack};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL %s @%0t: got phase=%0d l_a=%0d l_b=%0d walk=%b ack=%b, expected phase=%0d l_a=%0d l_b=%0d walk=%b ack=%b",
                 cur_name, $time, got_v[8:6], got_v[5:4], got_v[3:2], got_v[1], got_v[0],
                 exp_v[8:6], exp_v[5:4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: apply inputs, take one edge, push the
  // expected outputs for the state reached on that edge.
  task automatic tick(input logic ra, input logic rb, input logic rp, input logic rs,
                      input logic [2:0] ph, input logic ack, input string nm);
    bus.req_a   = ra;
    bus.req_b   = rb;
    bus.req_ped = rp;
    reset       = rs;
    @(posedge clk);
    #1;
    exp_q.push_back(make_exp(ph, ack));
    name_q.push_back(nm);
  endtask

  task automatic run(input int n, input logic ra, input logic rb, input logic rp,
                     input logic [2:0] ph, input string nm);
    for (int i = 0; i < n; i++) tick(ra, rb, rp, 1'b0, ph, 1'b0, nm);
  endtask

  task automatic do_reset(input string nm);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    bus.req_a   = 1'b0;
    bus.req_b   = 1'b0;
    bus.req_ped = 1'b0;
    @(posedge clk);
    #1;

    // Reset then idle: A green held for 100 cycles.
    do_reset("reset_state");
    run(100, 0, 0, 0, 3'd0, "idle_a_green");

    // Only B demands: 8 green (reset cycle + 7), 3 yellow, 2 clear, B green.
    do_reset("reset_gap");
    run(7, 0, 1, 0, 3'd0, "gap_a_green");
    run(3, 0, 1, 0, 3'd1, "gap_a_yellow");
    run(2, 0, 1, 0, 3'd2, "gap_a_clear");
    run(10, 0, 1, 0, 3'd3, "gap_b_green_hold");

    // Both roads demand: max-out at 32 cycles on each road.
    do_reset("reset_max");
    run(31, 1, 1, 0, 3'd0, "max_a_green");
    run(3, 1, 1, 0, 3'd1, "max_a_yellow");
    run(2, 1, 1, 0, 3'd2, "max_a_clear");
    run(32, 1, 1, 0, 3'd3, "max_b_green");
    run(3, 1, 1, 0, 3'd4, "max_b_yellow");
    run(2, 1, 1, 0, 3'd5, "max_b_clear");
    run(2, 1, 1, 0, 3'd0, "max_back_to_a");

    // Pedestrian press in A green; presses on the walk transition and in
    // the first walk cycle are absorbed, so B green is then held.
    do_reset("reset_ped");
    tick(0, 0, 1, 0, 3'd0, 0, "ped_press");
    run(6, 0, 0, 0, 3'd0, "ped_a_green");
    run(3, 0, 0, 0, 3'd1, "ped_a_yellow");
    run(2, 0, 0, 0, 3'd2, "ped_a_clear");
    tick(0, 0, 1, 0, 3'd6, 1, "ped_walk_entry");
    tick(0, 0, 1, 0, 3'd6, 0, "ped_walk_absorb");
    run(4, 0, 0, 0, 3'd6, "ped_walk");
    run(12, 0, 0, 0, 3'd3, "ped_b_green_hold");

    // Press during walk cycle 3: walk completes, B gaps out, walk again,
    // then A green because B cleared last.
    do_reset("reset_reped");
    tick(0, 0, 1, 0, 3'd0, 0, "reped_press");
    run(6, 0, 0, 0, 3'd0, "reped_a_green");
    run(3, 0, 0, 0, 3'd1, "reped_a_yellow");
    run(2, 0, 0, 0, 3'd2, "reped_a_clear");
    tick(0, 0, 0, 0, 3'd6, 1, "reped_walk1_entry");
    run(2, 0, 0, 0, 3'd6, "reped_walk1");
    tick(0, 0, 1, 0, 3'd6, 0, "reped_walk1_press");
    run(2, 0, 0, 0, 3'd6, "reped_walk1_tail");
    run(8, 0, 0, 0, 3'd3, "reped_b_green");
    run(3, 0, 0, 0, 3'd4, "reped_b_yellow");
    run(2, 0, 0, 0, 3'd5, "reped_b_clear");
    tick(0, 0, 0, 0, 3'd6, 1, "reped_walk2_entry");
    run(5, 0, 0, 0, 3'd6, "reped_walk2");
    run(3, 0, 0, 0, 3'd0, "reped_a_green_after");

    // Reset in B yellow with a pedestrian pending: demand is lost.
    do_reset("reset_mid_setup");
    run(7, 0, 1, 0, 3'd0, "mid_a_green");
    run(3, 0, 1, 0, 3'd1, "mid_a_yellow");
    run(2, 0, 1, 0, 3'd2, "mid_a_clear");
    tick(0, 1, 0, 0, 3'd3, 0, "mid_b_green");
    tick(1, 0, 1, 0, 3'd3, 0, "mid_b_green_press");
    run(6, 1, 0, 0, 3'd3, "mid_b_green");
    run(2, 1, 0, 0, 3'd4, "mid_b_yellow");
    tick(0, 0, 0, 1, 3'd0, 0, "mid_reset");
    run(20, 0, 0, 0, 3'd0, "mid_no_walk");

    // Drain the scoreboard; anything left unchecked is an error.
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
